cg_vector_stream_server: RTL and testbench
==========================================

// Module: cg_vector_stream_server
// PURPOSE
// - Ping-pong vector store serving one CG vector (r, p or x) to the CG ALU datapath, chunk by chunk.
// - Read side answers the ALU's per-chunk read strobes from the "old" bank.
// - Write side absorbs the ALU's write-back beats (mul_add results) into the "new" bank.
// - Banks swap at iteration end. One instance per vector; sits between the ALU and the vector memories.
// PARAMETERS
// - ELEMENT_WIDTH  32  bits per IEEE-754 single element
// - NO_OF_UNITS    8   elements per chunk (one read/write beat)
// - DEPTH          64  max chunks per bank
// - ADDR_W         6   clog2(DEPTH)
// PORTS
// - clk        in   1         clock; all logic on posedge
// - reset      in   1         asynchronous, active-low (0 = reset)
// - total      in   32        vector length in elements; sampled at every swap and while IDLE
// - rd_req     in   1         request next chunk from old bank
// - rd_restart in   1         rewind read pointer to chunk 0 (re-read pass)
// - rd_ready   out  1         a request would be accepted this cycle
// - rd_valid   out  1         rd_data valid (1-cycle pulse per accepted req)
// - rd_data    out  NU*EW     chunk; element 0 in LSBs
// - rd_last    out  1         asserted with rd_valid on final chunk
// - wr_en      in   1         write-back beat into new bank at wr_ptr
// - wr_data    in   NU*EW     write-back chunk
// - wr_last    out  1         registered; high once wr_ptr == chunks
// - swap       in   1         iteration end: exchange old/new banks
// - err        out  1         sticky: overflow write, early swap, or read on empty
// BEHAVIOUR
// - chunks = min(total/NU, DEPTH); total must be a multiple of NU. Remainder is ignored; total > NU*DEPTH clamps to DEPTH.
// - Reset values: rd_ready=0, rd_valid=0, rd_data=0, rd_last=0, wr_last=0, err=0; rd_ptr=wr_ptr=0; bank_sel=0; FSM=IDLE.
// - Bank contents are not reset.
// - FSM IDLE -> STREAM on first swap. STREAM -> DRAINED when rd_ptr reaches chunks. DRAINED -> STREAM on rd_restart or swap.
// - rd_ready = (STREAM && rd_ptr < chunks && chunks != 0).
// - Read accept: rd_req && rd_ready.
//   - Next cycle: rd_valid=1, rd_data = old[rd_ptr], rd_last = (rd_ptr == chunks-1).
//   - rd_ptr increments on accept.
//   - Back-to-back requests give one beat per cycle. Latency is exactly 1.
// - rd_req while !rd_ready: ignored, no rd_valid. Sets err only in DRAINED (overread).
// - rd_restart: rd_ptr <= 0 and FSM -> STREAM. A rd_req in the same cycle is ignored.
// - Write: wr_en writes new[wr_ptr] and increments wr_ptr. wr_last=1 when wr_ptr reaches chunks.
// - wr_en with wr_ptr == chunks: data dropped, err <= 1.
// - Reads and writes hit opposite banks, so there is no collision. Simultaneous rd and wr are both serviced.
// - swap checks the write count including a wr_en in the same cycle; that beat is committed before the swap.
// - On swap:
//   - bank_sel toggles; rd_ptr <= 0; wr_ptr <= 0; wr_last <= 0; chunks is resampled; FSM -> STREAM.
//   - If written beats != chunks, the swap still happens and err <= 1.
// - Swap has priority over rd_req and rd_restart in the same cycle: rd_req is dropped with no error.
//   A read accepted in the previous cycle still returns old-bank data on rd_valid.
// - chunks == 0 after swap: rd_ready stays 0, wr_last=1 immediately, swap is legal.
// - Asynchronous reset mid-stream clears all pointers, flags and the FSM immediately. No beat completes.
// STRUCTURE
// - Shared package cg_pkg holds:
//   - constants ELEMENT_WIDTH, NO_OF_UNITS
//   - typedef chunk_t (logic [NU*EW-1:0])
//   - FSM enum {IDLE, STREAM, DRAINED}
//   - CG control types
// - One sub-module, cg_vec_bank: DEPTH x chunk_t, 1 synchronous write port, 1 synchronous read port. Two instances.
// - Top holds the FSM, pointers, bank_sel, chunk calculation and err logic.
// TESTING
// - total=32 (4 chunks): write A0..A3, swap, 4 back-to-back rd_req -> rd_valid cycles 1..4 with data A0..A3; rd_last on A3; rd_ready=0 after.
// - Same setup: rd_restart after draining, then 2 reqs -> A0, A1 again; err stays 0.
// - After the first swap, write B0..B2 only, then swap -> err=1; reads return B0, B1, B2, then an unwritten slot.
// - rd_req and swap in the same cycle -> no rd_valid the next cycle; the following req returns the new bank's chunk 0.
// - 5th wr_en with chunks=4 -> dropped, err=1; rd of the old bank during writes returns unchanged data.
// - reset=0 asserted mid-stream (rd_ptr=2) -> all outputs 0 asynchronously; after release, FSM IDLE and rd_ready=0 until swap.

Source files
------------

// File: rtl/cg_pkg.sv
// cg_pkg: shared constants, chunk type, stream FSM states and CG control types
// for the CG vector datapath.
package cg_pkg;
    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 8;
    localparam int DEPTH         = 64;
    localparam int ADDR_W        = $clog2(DEPTH);
    localparam int CHUNK_W       = ELEMENT_WIDTH * NO_OF_UNITS;

    typedef logic [CHUNK_W-1:0] chunk_t;
    typedef logic [ADDR_W:0]    count_t;
    typedef enum logic [1:0] {IDLE, STREAM, DRAINED} state_t;
    typedef enum logic [1:0] {VEC_R, VEC_P, VEC_X} vec_id_t;

    // Whole chunks in a vector of `total` elements, clamped to one bank.
    function automatic count_t chunks_of(input logic [31:0] total);
        logic [31:0] c;
        c = total / 32'(NO_OF_UNITS);
        return (c > 32'(DEPTH)) ? count_t'(DEPTH) : c[ADDR_W:0];
    endfunction
endpackage

// File: rtl/cg_vec_bank.sv
// cg_vec_bank: DEPTH x chunk storage with one synchronous write and one
// synchronous (registered) read port; contents are never reset.
module cg_vec_bank
    import cg_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  chunk_t            wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output chunk_t            rq
);
    chunk_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rq <= mem[ra];
    end
endmodule

// File: rtl/cg_vector_stream_server.sv
// cg_vector_stream_server: ping-pong store for one CG vector; reads stream from
// the old bank while ALU write-back fills the new bank, banks swap per iteration.
module cg_vector_stream_server
    import cg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] total,
    input  logic        rd_req,
    input  logic        rd_restart,
    output logic        rd_ready,
    output logic        rd_valid,
    output chunk_t      rd_data,
    output logic        rd_last,
    input  logic        wr_en,
    input  chunk_t      wr_data,
    output logic        wr_last,
    input  logic        swap,
    output logic        err
);
    state_t state, state_n;
    count_t chunks, chunks_n, rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic   bank_sel, rd_src, accept, wr_do, err_n;
    chunk_t q [2];

    assign rd_ready = (state == STREAM) && (rd_ptr < chunks) && (chunks != '0);
    assign accept   = rd_req && rd_ready && !swap && !rd_restart;
    assign wr_do    = wr_en && (wr_ptr < chunks);
    assign rd_data  = rd_valid ? q[rd_src] : '0;

    always_comb begin
        chunks_n = (swap || state == IDLE) ? chunks_of(total) : chunks;
        wr_ptr_n = swap ? '0 : wr_ptr + count_t'(wr_do);
        rd_ptr_n = (swap || rd_restart) ? '0 : rd_ptr + count_t'(accept);
        state_n  = state;
        if (swap || (rd_restart && state != IDLE))
            state_n = STREAM;
        else if (state == STREAM && rd_ptr_n == chunks)
            state_n = DRAINED;
        // the swap-time count includes a beat written in the same cycle
        err_n = err || (wr_en && !wr_do)
                    || (swap && (wr_ptr + count_t'(wr_do)) != chunks)
                    || (rd_req && state == DRAINED && !swap && !rd_restart);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            chunks   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            bank_sel <= 1'b0;
            rd_src   <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            wr_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            chunks   <= chunks_n;
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr_n;
            bank_sel <= bank_sel ^ swap;
            rd_src   <= !bank_sel;
            rd_valid <= accept;
            rd_last  <= accept && (rd_ptr == chunks - count_t'(1));
            wr_last  <= (wr_ptr_n == chunks_n);
            err      <= err_n;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        cg_vec_bank u_bank (
            .clk (clk),
            .we  (wr_do && (bank_sel == 1'(i))),
            .wa  (wr_ptr[ADDR_W-1:0]),
            .wd  (wr_data),
            .re  (accept && (bank_sel != 1'(i))),
            .ra  (rd_ptr[ADDR_W-1:0]),
            .rq  (q[i])
        );
    end
endmodule

// File: tb/tb_cg_vector_stream_server.sv
// tb_cg_vector_stream_server: directed + randomized scoreboard bench; a
// behavioural model of the two banks predicts every read beat and flag.
module tb_cg_vector_stream_server;
    import cg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] total = 32'd32;
    logic        rd_req = 1'b0, rd_restart = 1'b0, wr_en = 1'b0, swap = 1'b0;
    chunk_t      wr_data = '0;
    logic        rd_ready, rd_valid, rd_last, wr_last, err;
    chunk_t      rd_data;

    cg_vector_stream_server dut (
        .clk        (clk),
        .reset      (reset),
        .total      (total),
        .rd_req     (rd_req),
        .rd_restart (rd_restart),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .swap       (swap),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {chunk_t data; logic last; logic known;} exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int compared = 0, mismatched = 0;

    // Reference model: two banks of retained contents, "new" bank index nb.
    chunk_t mem [2][DEPTH];
    bit     known [2][DEPTH];
    int     nb = 0, wcount = 0, rpos = 0, chunks = 0;
    bit     started = 0, rewound = 0, merr = 0;

    function automatic int nchunks(logic [31:0] t);
        int unsigned c;
        c = t / NO_OF_UNITS;
        return (c > DEPTH) ? DEPTH : int'(c);
    endfunction

    function automatic chunk_t rnd_chunk();
        chunk_t c;
        for (int k = 0; k < NO_OF_UNITS; k++) c[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = $urandom;
        return c;
    endfunction

    task automatic chk(string name, chunk_t act, chunk_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every DUT beat must match the oldest predicted beat, and every
    // predicted beat must appear exactly one cycle after its request.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rd_valid at %0t: got 1 expected 0", $time);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rd_last", chunk_t'(rd_last), chunk_t'(mon_e.last));
                    if (mon_e.known) chk("rd_data", rd_data, mon_e.data);
                end
            end else if (sbq.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL missing_rd_valid at %0t: got 0 expected 1", $time);
                void'(sbq.pop_front());
            end
        end
    end

    // One clock cycle: drive inputs at negedge, check, advance model at posedge.
    task automatic step(bit rq, bit rs, bit we, chunk_t wd, bit sw);
        bit ready, rew;
        rd_req = rq; rd_restart = rs; wr_en = we; wr_data = wd; swap = sw;
        ready = started && rpos < chunks;
        #1;
        chk("rd_ready", chunk_t'(rd_ready), chunk_t'(ready));
        @(posedge clk);
        rew = rewound;
        rewound = 0;
        if (we) begin
            if (wcount < chunks) begin
                mem[nb][wcount] = wd;
                known[nb][wcount] = 1;
                wcount++;
            end else merr = 1;
        end
        if (sw) begin
            if (wcount != chunks) merr = 1;
            nb ^= 1;
            chunks = nchunks(total);
            rpos = 0;
            wcount = 0;
            started = 1;
            rewound = 1;
        end else if (rs && started) begin
            rpos = 0;
            rewound = 1;
        end else if (rq) begin
            if (ready) begin
                sbq.push_back('{mem[nb^1][rpos], rpos == chunks - 1, known[nb^1][rpos]});
                rpos++;
            end else if (started && rpos == chunks && !rew) merr = 1;
        end
        if (!started) chunks = nchunks(total);
        @(negedge clk);
        chk("err", chunk_t'(err), chunk_t'(merr));
        chk("wr_last", chunk_t'(wr_last), chunk_t'(wcount == chunks));
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0);
    endtask

    // Asynchronous reset landing mid-cycle, right after a possible read accept.
    task automatic do_reset(bit rq);
        bit rdy;
        rdy = started && rpos < chunks;
        rd_req = rq; rd_restart = 0; wr_en = 0; swap = 0;
        @(posedge clk);
        #2;
        chk("pre_reset_valid", chunk_t'(rd_valid), chunk_t'(rq && rdy));
        reset = 0;
        #1;
        chk("rst_rd_valid", chunk_t'(rd_valid), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_last", chunk_t'(rd_last), '0);
        chk("rst_rd_ready", chunk_t'(rd_ready), '0);
        chk("rst_wr_last", chunk_t'(wr_last), '0);
        chk("rst_err", chunk_t'(err), '0);
        sbq.delete();
        nb = 0; wcount = 0; rpos = 0; chunks = 0;
        started = 0; rewound = 0; merr = 0;
        rd_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    chunk_t a [4], b [3], d [4], e [5];
    int unsigned totals [10] = '{0, 8, 24, 32, 37, 64, 128, 512, 520, 1000};

    initial begin
        for (int k = 0; k < 4; k++) begin a[k] = rnd_chunk(); d[k] = rnd_chunk(); end
        for (int k = 0; k < 3; k++) b[k] = rnd_chunk();
        for (int k = 0; k < 5; k++) e[k] = rnd_chunk();

        @(negedge clk);
        @(negedge clk);
        chk("init_rd_valid", chunk_t'(rd_valid), '0);
        chk("init_rd_ready", chunk_t'(rd_ready), '0);
        chk("init_err", chunk_t'(err), '0);
        chk("init_wr_last", chunk_t'(wr_last), '0);
        reset = 1;
        idle(1);

        // fill A, swap, drain back-to-back while writing B0..B2
        for (int k = 0; k < 4; k++) step(0, 0, 1, a[k], 0);
        step(0, 0, 0, '0, 1);
        for (int k = 0; k < 4; k++) step(1, 0, k < 3, (k < 3) ? b[k] : '0, 0);
        idle(1);
        // re-read pass
        step(0, 1, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        // short write count -> early swap error; read B's then an unwritten slot
        step(0, 0, 0, '0, 1);
        for (int k = 0; k < 5; k++) step(1, 0, 0, '0, 0);
        // reset mid-stream with rd_ptr at 2
        step(0, 1, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        do_reset(1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, '0, 0);

        // swap racing a read, then overflow write while reading the old bank
        for (int k = 0; k < 4; k++) step(0, 0, 1, rnd_chunk(), 0);
        step(0, 0, 0, '0, 1);
        step(1, 0, 1, d[0], 0);
        step(1, 0, 1, d[1], 0);
        step(0, 0, 1, d[2], 0);
        step(0, 0, 1, d[3], 0);
        step(1, 0, 0, '0, 1);
        for (int k = 0; k < 5; k++) step(k < 4, 0, 1, e[k], 0);
        idle(2);

        // randomized phases, each opened by a reset so err is re-armed
        for (int blk = 0; blk < 8; blk++) begin
            do_reset($urandom_range(0, 1) == 1);
            total = totals[$urandom_range(0, 9)];
            for (int k = 0; k < 250; k++) begin
                if ($urandom_range(0, 99) < 5) total = totals[$urandom_range(0, 9)];
                step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < 40, rnd_chunk(), $urandom_range(0, 99) < 4);
            end
        end
        idle(2);

        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
